// File: rtl/pipe_hazard_ctrl_if.sv
// Control bundle between the hazard sequencer and the pipeline it steers.
// master: the sequencer (reads hazard inputs, drives enables, bubbles, and status).
// slave: the pipeline side (drives hazard inputs, consumes enables, bubbles, and status).
// There is no ready/valid handshake on this bundle. Every hazard input is a level
// that is sampled each cycle. Every enable and bubble output is a combinational
// level that is valid for that same cycle.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    // hazard inputs
    logic             imem_stall;
    logic             dmem_stall;
    logic             dmem_done;
    logic             fd_valid;
    logic [2:0]       fd_rs;
    logic [2:0]       fd_rt;
    logic             fd_rs_used;
    logic             fd_rt_used;
    logic             dx_valid;
    logic             dx_MemRead;
    logic [2:0]       dx_rf_write_reg;
    logic             x_branch_taken;
    logic             mw_valid;
    logic             mw_halt;
    // latch controls
    logic             pc_we;
    logic             fd_we;
    logic             dx_we;
    logic             xm_we;
    logic             mw_we;
    logic             fd_bubble;
    logic             dx_bubble;
    logic             mw_bubble;
    // status
    logic             halted;
    logic             dmem_timeout;
    logic [CNT_W-1:0] stall_cycles;
    logic [1:0]       dbg_state;

    modport master (
        input  imem_stall, dmem_stall, dmem_done, fd_valid, fd_rs, fd_rt,
               fd_rs_used, fd_rt_used, dx_valid, dx_MemRead, dx_rf_write_reg,
               x_branch_taken, mw_valid, mw_halt,
        output pc_we, fd_we, dx_we, xm_we, mw_we, fd_bubble, dx_bubble, mw_bubble,
               halted, dmem_timeout, stall_cycles, dbg_state
    );

    modport slave (
        output imem_stall, dmem_stall, dmem_done, fd_valid, fd_rs, fd_rt,
               fd_rs_used, fd_rt_used, dx_valid, dx_MemRead, dx_rf_write_reg,
               x_branch_taken, mw_valid, mw_halt,
        input  pc_we, fd_we, dx_we, xm_we, mw_we, fd_bubble, dx_bubble, mw_bubble,
               halted, dmem_timeout, stall_cycles, dbg_state
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// It drives the PC and the FD/DX/XM/MW latch write enables and the bubble inserts.
// It resolves halt, multi-cycle data memory accesses, taken branches, load-use
// hazards, and instruction memory misses, in that priority order.
// The FSM state is exposed on dbg_state (RUN=0, DMEM_WAIT=1, HALTED=2).
module pipe_hazard_ctrl #(
    parameter int unsigned MAX_WAIT = 64,
    parameter int unsigned CNT_W    = 16
) (
    input  logic clk,
    input  logic rst,
    pipe_hazard_ctrl_if.master bus
);
    localparam int unsigned WAIT_W = 16;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        DMEM_WAIT = 2'd1,
        HALTED    = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic pc_we, fd_we, dx_we, xm_we, mw_we;
    logic fd_bubble, dx_bubble, mw_bubble;
    logic load_use;

    // The instruction in FD reads the register that the load in DX has not produced yet.
    assign load_use = bus.dx_valid & bus.dx_MemRead & bus.fd_valid &
                      ((bus.fd_rs_used & (bus.fd_rs == bus.dx_rf_write_reg)) |
                       (bus.fd_rt_used & (bus.fd_rt == bus.dx_rf_write_reg)));

    // Next-state and latch-control decode; reset overrides everything to flush all latches.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        pc_we      = 1'b1;
        fd_we      = 1'b1;
        dx_we      = 1'b1;
        xm_we      = 1'b1;
        mw_we      = 1'b1;
        fd_bubble  = 1'b0;
        dx_bubble  = 1'b0;
        mw_bubble  = 1'b0;

        case (state_q)
            RUN: begin
                if (bus.mw_valid && bus.mw_halt) begin
                    // The halt is already in MW, so freeze everything.
                    {pc_we, fd_we, dx_we, xm_we, mw_we} = 5'b0;
                    state_d = HALTED;
                end else if (bus.dmem_stall && !bus.dmem_done) begin
                    // Hold up to XM and drain MW with a bubble while memory works.
                    {pc_we, fd_we, dx_we, xm_we} = 4'b0;
                    mw_bubble  = 1'b1;
                    state_d    = DMEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end else if (bus.x_branch_taken) begin
                    // Both younger instructions are on the wrong path.
                    fd_bubble = 1'b1;
                    dx_bubble = 1'b1;
                end else if (load_use) begin
                    // Hold FD and the PC for one cycle, and inject one bubble into DX.
                    pc_we     = 1'b0;
                    fd_we     = 1'b0;
                    dx_bubble = 1'b1;
                end else if (bus.imem_stall) begin
                    pc_we     = 1'b0;
                    fd_bubble = 1'b1;
                end
            end
            DMEM_WAIT: begin
                if (bus.dmem_done) begin
                    // Load data lands in MW and everything advances.
                    // Other hazards are re-evaluated next cycle.
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q >= WAIT_W'(MAX_WAIT)) begin
                    // Memory never answered, so stop the machine from this cycle on.
                    {pc_we, fd_we, dx_we, xm_we, mw_we} = 5'b0;
                    state_d    = HALTED;
                    timeout_d  = 1'b1;
                    wait_cnt_d = '0;
                end else begin
                    {pc_we, fd_we, dx_we, xm_we} = 4'b0;
                    mw_bubble  = 1'b1;
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            HALTED: begin
                {pc_we, fd_we, dx_we, xm_we, mw_we} = 5'b0;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        if (rst) begin
            {pc_we, fd_we, dx_we, xm_we, mw_we} = 5'b11111;
            {fd_bubble, dx_bubble, mw_bubble}   = 3'b111;
        end
    end

    // Count frontend-stalled cycles while the machine is live, saturating at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!rst && (state_q != HALTED) && !pc_we && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State, wait counter, sticky timeout and stall counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.pc_we        = pc_we;
    assign bus.fd_we        = fd_we;
    assign bus.dx_we        = dx_we;
    assign bus.xm_we        = xm_we;
    assign bus.mw_we        = mw_we;
    assign bus.fd_bubble    = fd_bubble;
    assign bus.dx_bubble    = dx_bubble;
    assign bus.mw_bubble    = mw_bubble;
    assign bus.halted       = (state_q == HALTED);
    assign bus.dmem_timeout = timeout_q;
    assign bus.stall_cycles = stall_cnt_q;
    assign bus.dbg_state    = state_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus a randomized run against a
// cycle-level reference model of the stall/flush rules.
module tb_pipe_hazard_ctrl;
    localparam int MAXW = 4;
    localparam int CNTW = 4;
    localparam int CMAX = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(CNTW)) bus ();

    pipe_hazard_ctrl #(.MAX_WAIT(MAXW), .CNT_W(CNTW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // reference model state
    bit m_wait = 0;
    bit m_stop = 0;
    bit m_tmo  = 0;
    int m_len  = 0;
    int m_cnt  = 0;

    // {pc,fd,dx,xm,mw}_we, {fd,dx,mw}_bubble
    logic [7:0] dut_outs;
    assign dut_outs = {bus.pc_we, bus.fd_we, bus.dx_we, bus.xm_we, bus.mw_we,
                       bus.fd_bubble, bus.dx_bubble, bus.mw_bubble};

    function automatic logic [7:0] ref_outs();
        bit lu;
        lu = bus.dx_valid && bus.dx_MemRead && bus.fd_valid &&
             ((bus.fd_rs_used && bus.fd_rs == bus.dx_rf_write_reg) ||
              (bus.fd_rt_used && bus.fd_rt == bus.dx_rf_write_reg));
        if (rst) return 8'b11111_111;
        if (m_stop) return 8'b00000_000;
        if (m_wait) begin
            if (bus.dmem_done) return 8'b11111_000;
            if (m_len >= MAXW) return 8'b00000_000;
            return 8'b00001_001;
        end
        if (bus.mw_valid && bus.mw_halt) return 8'b00000_000;
        if (bus.dmem_stall && !bus.dmem_done) return 8'b00001_001;
        if (bus.x_branch_taken) return 8'b11111_110;
        if (lu) return 8'b00111_010;
        if (bus.imem_stall) return 8'b01111_100;
        return 8'b11111_000;
    endfunction

    function automatic logic [1:0] ref_state();
        if (m_stop) return 2'd2;
        if (m_wait) return 2'd1;
        return 2'd0;
    endfunction

    task automatic idle();
        bus.imem_stall = 0; bus.dmem_stall = 0; bus.dmem_done = 0;
        bus.fd_valid = 0; bus.fd_rs = 0; bus.fd_rt = 0; bus.fd_rs_used = 0; bus.fd_rt_used = 0;
        bus.dx_valid = 0; bus.dx_MemRead = 0; bus.dx_rf_write_reg = 0;
        bus.x_branch_taken = 0; bus.mw_valid = 0; bus.mw_halt = 0;
    endtask

    // One clock: advance the model on the rising edge and return on the falling edge.
    task automatic tick();
        logic [7:0] e;
        e = ref_outs();
        @(posedge clk);
        if (rst) begin
            m_wait = 0; m_stop = 0; m_tmo = 0; m_len = 0; m_cnt = 0;
        end else begin
            if (!m_stop && !e[7] && m_cnt < CMAX) m_cnt++;
            if (m_stop) begin
                // stays stopped until reset
            end else if (m_wait) begin
                if (bus.dmem_done) begin
                    m_wait = 0; m_len = 0;
                end else if (m_len >= MAXW) begin
                    m_stop = 1; m_tmo = 1; m_wait = 0; m_len = 0;
                end else begin
                    m_len++;
                end
            end else if (bus.mw_valid && bus.mw_halt) begin
                m_stop = 1;
            end else if (bus.dmem_stall && !bus.dmem_done) begin
                m_wait = 1; m_len = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1; idle();
        tick(); tick();
        rst = 0;
    endtask

    task automatic set_load_r3();
        bus.dx_valid = 1; bus.dx_MemRead = 1; bus.dx_rf_write_reg = 3'd3;
        bus.fd_valid = 1; bus.fd_rs = 3'd3; bus.fd_rs_used = 1;
    endtask

    task automatic test_reset();
        rst = 1; idle(); #1;
        total++; if (dut_outs !== 8'hFF) begin bad++; $display("FAIL rst_outs got=%b exp=%b", dut_outs, 8'hFF); end
        tick(); tick();
        rst = 0; #1;
        total++; if (dut_outs !== 8'b11111_000) begin bad++; $display("FAIL post_rst_outs got=%b exp=%b", dut_outs, 8'b11111_000); end
        total++; if ({bus.halted, bus.dmem_timeout} !== 2'b00) begin bad++; $display("FAIL post_rst_flags got=%b exp=00", {bus.halted, bus.dmem_timeout}); end
        total++; if (bus.stall_cycles !== 4'd0) begin bad++; $display("FAIL post_rst_cnt got=%0d exp=0", bus.stall_cycles); end
        total++; if (bus.dbg_state !== 2'd0) begin bad++; $display("FAIL post_rst_state got=%0d exp=0", bus.dbg_state); end
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        set_load_r3(); #1;
        total++; if (dut_outs !== 8'b00111_010) begin bad++; $display("FAIL lu_rs got=%b exp=%b", dut_outs, 8'b00111_010); end
        tick();
        bus.dx_valid = 0; #1;
        total++; if (dut_outs !== 8'b11111_000) begin bad++; $display("FAIL lu_after got=%b exp=%b", dut_outs, 8'b11111_000); end
        total++; if (bus.stall_cycles !== 4'd1) begin bad++; $display("FAIL lu_cnt got=%0d exp=1", bus.stall_cycles); end
        tick();
        bus.dx_valid = 1; bus.fd_rs_used = 0; bus.fd_rs = 3'd5; bus.fd_rt = 3'd3; bus.fd_rt_used = 1; #1;
        total++; if (dut_outs !== 8'b00111_010) begin bad++; $display("FAIL lu_rt got=%b exp=%b", dut_outs, 8'b00111_010); end
        tick();
        bus.fd_rt_used = 0; bus.fd_rs = 3'd3; #1;
        total++; if (dut_outs !== 8'b11111_000) begin bad++; $display("FAIL lu_unused got=%b exp=%b", dut_outs, 8'b11111_000); end
        tick();
        bus.fd_rs_used = 1; bus.fd_rs = 3'd4; #1;
        total++; if (dut_outs !== 8'b11111_000) begin bad++; $display("FAIL lu_other_reg got=%b exp=%b", dut_outs, 8'b11111_000); end
        tick();
        bus.fd_rs = 3'd3; bus.dx_MemRead = 0; #1;
        total++; if (dut_outs !== 8'b11111_000) begin bad++; $display("FAIL lu_not_load got=%b exp=%b", dut_outs, 8'b11111_000); end
        tick();
        total++; if (bus.stall_cycles !== 4'd2) begin bad++; $display("FAIL lu_cnt2 got=%0d exp=2", bus.stall_cycles); end
        idle();
    endtask

    task automatic test_branch();
        do_reset();
        set_load_r3(); bus.imem_stall = 1; bus.x_branch_taken = 1; #1;
        total++; if (dut_outs !== 8'b11111_110) begin bad++; $display("FAIL br_lu got=%b exp=%b", dut_outs, 8'b11111_110); end
        tick();
        bus.x_branch_taken = 0; #1;
        total++; if (dut_outs !== 8'b00111_010) begin bad++; $display("FAIL lu_over_imem got=%b exp=%b", dut_outs, 8'b00111_010); end
        tick();
        bus.dx_valid = 0; #1;
        total++; if (dut_outs !== 8'b01111_100) begin bad++; $display("FAIL imem got=%b exp=%b", dut_outs, 8'b01111_100); end
        tick();
        total++; if (bus.stall_cycles !== 4'd2) begin bad++; $display("FAIL br_cnt got=%0d exp=2", bus.stall_cycles); end
        idle();
    endtask

    task automatic test_dmem_miss();
        do_reset();
        bus.dmem_stall = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (dut_outs !== 8'b00001_001) begin bad++; $display("FAIL miss_hold%0d got=%b exp=%b", i, dut_outs, 8'b00001_001); end
            tick();
        end
        total++; if (bus.dbg_state !== 2'd1) begin bad++; $display("FAIL miss_state got=%0d exp=1", bus.dbg_state); end
        bus.dmem_done = 1; bus.x_branch_taken = 1; bus.imem_stall = 1; #1;
        total++; if (dut_outs !== 8'b11111_000) begin bad++; $display("FAIL miss_done got=%b exp=%b", dut_outs, 8'b11111_000); end
        tick();
        idle(); #1;
        total++; if (bus.dbg_state !== 2'd0) begin bad++; $display("FAIL miss_back_run got=%0d exp=0", bus.dbg_state); end
        total++; if (bus.stall_cycles !== 4'd3) begin bad++; $display("FAIL miss_cnt got=%0d exp=3", bus.stall_cycles); end
        bus.dmem_stall = 1; bus.dmem_done = 1; #1;
        total++; if (dut_outs !== 8'b11111_000) begin bad++; $display("FAIL hit got=%b exp=%b", dut_outs, 8'b11111_000); end
        tick();
        idle(); #1;
        total++; if ({bus.dbg_state, bus.stall_cycles} !== {2'd0, 4'd3}) begin bad++; $display("FAIL hit_after got=%h exp=%h", {bus.dbg_state, bus.stall_cycles}, {2'd0, 4'd3}); end
    endtask

    task automatic test_timeout();
        do_reset();
        bus.dmem_stall = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if (dut_outs !== 8'b00001_001) begin bad++; $display("FAIL to_hold%0d got=%b exp=%b", i, dut_outs, 8'b00001_001); end
            tick();
        end
        #1;
        total++; if (dut_outs !== 8'b00000_000) begin bad++; $display("FAIL to_edge got=%b exp=0", dut_outs); end
        total++; if (bus.halted !== 1'b0) begin bad++; $display("FAIL to_early_halt got=%b exp=0", bus.halted); end
        tick(); #1;
        total++; if ({bus.halted, bus.dmem_timeout, bus.dbg_state} !== 4'b11_10) begin bad++; $display("FAIL to_flags got=%b exp=1110", {bus.halted, bus.dmem_timeout, bus.dbg_state}); end
        total++; if (bus.stall_cycles !== 4'd5) begin bad++; $display("FAIL to_cnt got=%0d exp=5", bus.stall_cycles); end
        bus.dmem_done = 1; tick(); bus.dmem_done = 0; tick(); tick(); #1;
        total++; if (dut_outs !== 8'b00000_000) begin bad++; $display("FAIL to_frozen got=%b exp=0", dut_outs); end
        total++; if (bus.stall_cycles !== 4'd5) begin bad++; $display("FAIL to_cnt_frozen got=%0d exp=5", bus.stall_cycles); end
        rst = 1; #1;
        total++; if (dut_outs !== 8'hFF) begin bad++; $display("FAIL to_rst_outs got=%b exp=%b", dut_outs, 8'hFF); end
        tick();
        rst = 0; idle(); #1;
        total++; if ({bus.halted, bus.dmem_timeout, bus.dbg_state, bus.stall_cycles} !== 8'h00) begin bad++; $display("FAIL to_cleared got=%h exp=00", {bus.halted, bus.dmem_timeout, bus.dbg_state, bus.stall_cycles}); end
        total++; if (dut_outs !== 8'b11111_000) begin bad++; $display("FAIL to_run_outs got=%b exp=%b", dut_outs, 8'b11111_000); end
    endtask

    task automatic test_halt();
        do_reset();
        bus.mw_halt = 1; #1;
        total++; if (dut_outs !== 8'b11111_000) begin bad++; $display("FAIL halt_invalid got=%b exp=%b", dut_outs, 8'b11111_000); end
        tick();
        bus.mw_valid = 1; bus.dmem_stall = 1; #1;
        total++; if (dut_outs !== 8'b00000_000) begin bad++; $display("FAIL halt_outs got=%b exp=0", dut_outs); end
        total++; if (bus.halted !== 1'b0) begin bad++; $display("FAIL halt_early got=%b exp=0", bus.halted); end
        tick();
        idle(); bus.imem_stall = 1; #1;
        total++; if ({bus.halted, bus.dmem_timeout, bus.dbg_state} !== 4'b10_10) begin bad++; $display("FAIL halt_flags got=%b exp=1010", {bus.halted, bus.dmem_timeout, bus.dbg_state}); end
        total++; if (bus.stall_cycles !== 4'd1) begin bad++; $display("FAIL halt_cnt got=%0d exp=1", bus.stall_cycles); end
        tick(); tick(); #1;
        total++; if (bus.stall_cycles !== 4'd1) begin bad++; $display("FAIL halt_cnt_frozen got=%0d exp=1", bus.stall_cycles); end
        rst = 1; #1;
        total++; if (dut_outs !== 8'hFF) begin bad++; $display("FAIL halt_rst_outs got=%b exp=%b", dut_outs, 8'hFF); end
        tick();
        rst = 0; idle(); #1;
        total++; if ({bus.halted, bus.dbg_state, bus.stall_cycles} !== 7'd0) begin bad++; $display("FAIL halt_cleared got=%h exp=0", {bus.halted, bus.dbg_state, bus.stall_cycles}); end
    endtask

    task automatic test_saturation();
        do_reset();
        bus.imem_stall = 1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 14) begin
                total++; if (bus.stall_cycles !== 4'd14) begin bad++; $display("FAIL sat_14 got=%0d exp=14", bus.stall_cycles); end
            end
        end
        total++; if (bus.stall_cycles !== 4'd15) begin bad++; $display("FAIL sat_hold got=%0d exp=15", bus.stall_cycles); end
        idle();
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        bus.dmem_stall = 1;
        tick(); tick();
        rst = 1; tick();
        rst = 0; bus.dmem_stall = 0; bus.dmem_done = 1; #1;
        total++; if (bus.dbg_state !== 2'd0) begin bad++; $display("FAIL rmw_state got=%0d exp=0", bus.dbg_state); end
        total++; if (dut_outs !== 8'b11111_000) begin bad++; $display("FAIL rmw_outs got=%b exp=%b", dut_outs, 8'b11111_000); end
        tick();
        total++; if ({bus.dbg_state, bus.stall_cycles} !== 6'd0) begin bad++; $display("FAIL rmw_after got=%h exp=0", {bus.dbg_state, bus.stall_cycles}); end
        idle();
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            rst = m_stop ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 59) == 0);
            bus.imem_stall     = ($urandom_range(0, 3) == 0);
            bus.dmem_stall     = ($urandom_range(0, 5) == 0);
            bus.dmem_done      = m_wait ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 5) == 0);
            bus.fd_valid       = ($urandom_range(0, 3) != 0);
            bus.fd_rs          = 3'($urandom_range(0, 3));
            bus.fd_rt          = 3'($urandom_range(0, 3));
            bus.fd_rs_used     = $urandom_range(0, 1);
            bus.fd_rt_used     = $urandom_range(0, 1);
            bus.dx_valid       = ($urandom_range(0, 3) != 0);
            bus.dx_MemRead     = $urandom_range(0, 1);
            bus.dx_rf_write_reg = 3'($urandom_range(0, 3));
            bus.x_branch_taken = ($urandom_range(0, 4) == 0);
            bus.mw_valid       = $urandom_range(0, 1);
            bus.mw_halt        = ($urandom_range(0, 29) == 0);
            #1;
            total++; if (dut_outs !== ref_outs()) begin bad++; $display("FAIL rnd_outs cyc=%0d got=%b exp=%b", n, dut_outs, ref_outs()); end
            total++; if ({bus.halted, bus.dmem_timeout} !== {m_stop, m_tmo}) begin bad++; $display("FAIL rnd_flags cyc=%0d got=%b exp=%b", n, {bus.halted, bus.dmem_timeout}, {m_stop, m_tmo}); end
            total++; if (bus.stall_cycles !== 4'(m_cnt)) begin bad++; $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", n, bus.stall_cycles, m_cnt); end
            total++; if (bus.dbg_state !== ref_state()) begin bad++; $display("FAIL rnd_state cyc=%0d got=%0d exp=%0d", n, bus.dbg_state, ref_state()); end
            tick();
        end
        rst = 0; idle();
    endtask

    initial begin
        idle();
        @(negedge clk);
        test_reset();
        test_load_use();
        test_branch();
        test_dmem_miss();
        test_timeout();
        test_halt();
        test_saturation();
        test_reset_mid_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
